// File: rtl/seg_scan_controller.sv
// seg_scan_controller: double-buffered 4-digit 7-seg scanner with anti-ghost blanking and 16-step PWM.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg_scan_controller #(
  parameter int SCAN_DIV     = 800_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [15:0] load_data_i,
  input  logic [3:0]  load_dp_i,
  input  logic [3:0]  brightness_i,
  output logic [1:0]  digit_sel_o,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_done_o
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [15:0][6:0] HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  typedef enum logic {BLANK, ON} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] slot_q, slot_d;
  logic [1:0] dig_q, dig_d, sel_q, sel_d;
  logic [3:0] pwm_q, pwm_d, bright_q, bright_d;
  logic [15:0] act_data_q, act_data_d, sh_data_q, sh_data_d;
  logic [3:0] act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic sh_full_q, sh_full_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d, fd_q, fd_d;
  logic wrap, boundary, accept, lit, blank;
  logic [3:0] nib;
`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] lz;
`endif
  always_comb begin
    wrap       = slot_q == CW'(SCAN_DIV - 1);
    boundary   = wrap && dig_q == 2'd3;
    accept     = load_valid_i && !sh_full_q;
    slot_d     = wrap ? '0 : slot_q + 1'b1;
    dig_d      = wrap ? dig_q + 2'd1 : dig_q;
    pwm_d      = wrap ? 4'd0 : pwm_q + 4'd1;
    state_d    = slot_d < CW'(BLANK_CYCLES) ? BLANK : ON;
    bright_d   = slot_q == '0 ? brightness_i : bright_q;
    sh_full_d  = accept ? 1'b1 : boundary ? 1'b0 : sh_full_q;
    sh_data_d  = accept ? load_data_i : sh_data_q;
    sh_dp_d    = accept ? load_dp_i : sh_dp_q;
    act_data_d = boundary && sh_full_q ? sh_data_q : act_data_q;
    act_dp_d   = boundary && sh_full_q ? sh_dp_q : act_dp_q;
    nib        = act_data_q[{dig_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    lz         = {act_data_q[15:12] == 4'd0, act_data_q[15:8] == 8'd0, act_data_q[15:4] == 12'd0, 1'b0};
    blank      = lz[dig_q] && !act_dp_q[dig_q];
`else
    blank      = 1'b0;
`endif
    lit        = state_q == ON && pwm_q <= bright_q;
    an_d       = lit ? ~(4'b0001 << dig_q) : 4'hF;
    seg_d      = state_q == BLANK || blank ? 7'h7F : HEX[nib];
    dp_d       = lit && !blank ? ~act_dp_q[dig_q] : 1'b1;
    fd_d       = boundary;
    sel_d      = dig_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= BLANK;
      slot_q     <= '0;
      dig_q      <= 2'd0;
      sel_q      <= 2'd0;
      pwm_q      <= 4'd0;
      bright_q   <= 4'd0;
      act_data_q <= 16'd0;
      act_dp_q   <= 4'd0;
      sh_data_q  <= 16'd0;
      sh_dp_q    <= 4'd0;
      sh_full_q  <= 1'b0;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      dig_q      <= dig_d;
      sel_q      <= sel_d;
      pwm_q      <= pwm_d;
      bright_q   <= bright_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_full_q  <= sh_full_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
    end
  end
  assign load_ready_o = !sh_full_q;
  assign digit_sel_o  = sel_q;
  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign frame_done_o = fd_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: table-driven scoreboard bench for seg_scan_controller (SCAN_DIV=20, BLANK_CYCLES=4).
module tb_seg_scan_controller;
  logic clk = 1'b0, rst_n = 1'b0, load_valid = 1'b0, load_ready, dp, frame_done;
  logic [15:0] load_data = 16'd0;
  logic [3:0] load_dp = 4'd0, brightness = 4'd15, an;
  logic [1:0] digit_sel;
  logic [6:0] seg;
  int checks = 0, errors = 0;
  typedef struct {logic [15:0] data; logic [3:0] dpv; logic [6:0] s0, s1, s2, s3;} vec_t;
  typedef struct {logic [1:0] d; logic [3:0] an; logic [6:0] seg; logic dp;} exp_t;
  exp_t sb[$];
  vec_t vt[6];
  vec_t zero_v;
  always #5 clk = ~clk;
  seg_scan_controller #(.SCAN_DIV(20), .BLANK_CYCLES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .load_valid_i(load_valid), .load_ready_o(load_ready),
    .load_data_i(load_data), .load_dp_i(load_dp), .brightness_i(brightness),
    .digit_sel_o(digit_sel), .an_o(an), .seg_o(seg), .dp_o(dp), .frame_done_o(frame_done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (rst_n) chk("an_onehot", 32'($countones(~an) > 1), 32'd0);
  task automatic push_exp(input vec_t v);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      e.d   = 2'(d);
      e.an  = ~(4'b0001 << d);
      e.seg = d == 0 ? v.s0 : d == 1 ? v.s1 : d == 2 ? v.s2 : v.s3;
      e.dp  = ~v.dpv[d];
      sb.push_back(e);
    end
  endtask
  task automatic wait_ready(input logic lvl);
    int n = 0;
    while (load_ready !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", 32'(load_ready), 32'(lvl));
  endtask
  task automatic wait_fd();
    int n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_frame_done", 32'(frame_done), 32'd1);
  endtask
  task automatic wait_an(input logic idle);
    int n = 0;
    while ((an === 4'hF) !== idle && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_an", 32'(an === 4'hF), 32'(idle));
  endtask
  task automatic load(input vec_t v);
    wait_ready(1'b1);
    load_valid = 1'b1;
    load_data  = v.data;
    load_dp    = v.dpv;
    push_exp(v);
    @(negedge clk);
    load_valid = 1'b0;
    chk("ready_drop", 32'(load_ready), 32'd0);
  endtask
  task automatic scan();
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      wait_an(1'b1);
      wait_an(1'b0);
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("digit_sel", 32'(digit_sel), 32'(e.d));
        chk("an", 32'(an), 32'(e.an));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("dp", 32'(dp), 32'(e.dp));
      end
    end
  endtask
  initial begin
    int cnt;
    vt[0] = '{16'h1234, 4'b0000, 7'h19, 7'h30, 7'h24, 7'h79};
    vt[1] = '{16'hABCD, 4'b0101, 7'h21, 7'h46, 7'h03, 7'h08};
    vt[2] = '{16'h89EF, 4'b1000, 7'h0E, 7'h06, 7'h10, 7'h00};
    vt[3] = '{16'h5670, 4'b0010, 7'h40, 7'h78, 7'h02, 7'h12};
`ifdef LEADING_ZERO_BLANK_EN
    vt[4] = '{16'h0070, 4'b0000, 7'h40, 7'h78, 7'h7F, 7'h7F};
    vt[5] = '{16'h0000, 4'b0000, 7'h40, 7'h7F, 7'h7F, 7'h7F};
`else
    vt[4] = '{16'h0070, 4'b0000, 7'h40, 7'h78, 7'h40, 7'h40};
    vt[5] = '{16'h0000, 4'b0000, 7'h40, 7'h40, 7'h40, 7'h40};
`endif
    zero_v = vt[5];
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_digit_sel", 32'(digit_sel), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    load_valid = 1'b1;
    load_data  = 16'h1234;
    @(negedge clk);
    load_valid = 1'b0;
    chk("pre_rst_ready", 32'(load_ready), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_ready", 32'(load_ready), 32'd1);
    rst_n = 1'b1;
    push_exp(zero_v);
    wait_fd();
    scan();
    for (int i = 0; i < 6; i++) begin
      load(vt[i]);
      wait_ready(1'b1);
      chk("fd_at_swap", 32'(frame_done), 32'd1);
      scan();
    end
    load(vt[0]);
    load_valid = 1'b1;
    load_data  = vt[1].data;
    load_dp    = vt[1].dpv;
    push_exp(vt[1]);
    wait_ready(1'b1);
    chk("b2b_fd1", 32'(frame_done), 32'd1);
    @(negedge clk);
    load_valid = 1'b0;
    chk("b2b_b_accepted", 32'(load_ready), 32'd0);
    scan();
    wait_ready(1'b1);
    chk("b2b_fd2", 32'(frame_done), 32'd1);
    scan();
    wait_fd();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("blank_window", 32'(an), 32'hF);
    end
    @(negedge clk);
    chk("first_on_cycle", 32'(an), 32'hE);
    brightness = 4'd0;
    wait_fd();
    cnt = 0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (an !== 4'hF) cnt++;
    end
    chk("pwm_min_count", 32'(cnt), 32'd4);
    wait_fd();
    cnt = 0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (j == 1) brightness = 4'd15;
      if (an !== 4'hF) cnt++;
    end
    chk("pwm_midslot_count", 32'(cnt), 32'd49);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
